// File: rtl/mux_pkg.sv
// Shared constants and the lane-select type for the registered 8-to-1 multiplexer.
package mux_pkg;
   localparam int N_IN  = 8;
   localparam int SEL_W = $clog2(N_IN);

   typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux_2_to_1.sv
// Combinational 2:1 lane select. One node of the 3-level tree inside mux_8to1.
module mux_2_to_1 #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);
   assign y = sel ? d1 : d0;
endmodule

// File: rtl/mux_8to1.sv
// Registered 8-to-1 lane multiplexer: a 3-level 2:1 tree feeding one output register.
module mux_8to1
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [N_IN*WIDTH-1:0] a_i,
   input  logic [SEL_W-1:0]      s_i,
   output logic [WIDTH-1:0]      y_o
);
   sel_t             sel;
   logic [WIDTH-1:0] lane [N_IN];
   logic [WIDTH-1:0] lvl0 [4];
   logic [WIDTH-1:0] lvl1 [2];
   logic [WIDTH-1:0] tree_y;
   logic [WIDTH-1:0] y_next;

   assign sel = s_i;

   for (genvar k = 0; k < N_IN; k++) begin : g_lane
      assign lane[k] = a_i[k*WIDTH +: WIDTH];
   end

   for (genvar i = 0; i < 4; i++) begin : g_lvl0
      mux_2_to_1 #(.WIDTH(WIDTH)) u_mux (
         .d0  (lane[2*i]),
         .d1  (lane[2*i+1]),
         .sel (sel[0]),
         .y   (lvl0[i])
      );
   end

   for (genvar i = 0; i < 2; i++) begin : g_lvl1
      mux_2_to_1 #(.WIDTH(WIDTH)) u_mux (
         .d0  (lvl0[2*i]),
         .d1  (lvl0[2*i+1]),
         .sel (sel[1]),
         .y   (lvl1[i])
      );
   end

   mux_2_to_1 #(.WIDTH(WIDTH)) u_lvl2 (
      .d0  (lvl1[0]),
      .d1  (lvl1[1]),
      .sel (sel[2]),
      .y   (tree_y)
   );

   // An unknown select resolves to zeros instead of propagating X into the register.
   always_comb begin
      y_next = '0;
      case (sel)
         3'd0, 3'd1, 3'd2, 3'd3,
         3'd4, 3'd5, 3'd6, 3'd7: y_next = tree_y;
         default:                y_next = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) y_o <= '0;
      else       y_o <= y_next;
   end
endmodule

// File: tb/tb_mux_8to1.sv
// Bench for mux_8to1: WIDTH=1 and WIDTH=4 instances checked against an arithmetic lane model.
module tb_mux_8to1;
   logic        clk;
   logic        rst;
   logic [7:0]  a1;
   logic [2:0]  s1;
   logic        y1;
   logic [31:0] a4;
   logic [2:0]  s4;
   logic [3:0]  y4;

   int errors = 0;
   int checks = 0;

   mux_8to1 #(.WIDTH(1)) dut1 (
      .clk_i (clk),
      .rst_i (rst),
      .a_i   (a1),
      .s_i   (s1),
      .y_o   (y1)
   );

   mux_8to1 #(.WIDTH(4)) dut4 (
      .clk_i (clk),
      .rst_i (rst),
      .a_i   (a4),
      .s_i   (s4),
      .y_o   (y4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lane k of a packed bus is bits [k*w +: w]; shift-and-mask gives it directly.
   function automatic logic [3:0] lane_of(logic [31:0] a, int s, int w);
      logic [31:0] v;
      v = (a >> (s * w)) & ((32'd1 << w) - 32'd1);
      return v[3:0];
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      a1  = 8'hFF;
      s1  = 3'd3;
      a4  = 32'hFFFF_FFFF;
      s4  = 3'd3;
      #1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (y1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_edge got=%b exp=0", y1);
         end
         checks++;
         if (y4 !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold_w4 got=%h exp=0", y4);
         end
         @(negedge clk);
         checks++;
         if (y1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_mid got=%b exp=0", y1);
         end
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (y1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_release got=%b exp=1", y1);
      end
      checks++;
      if (y4 !== 4'hF) begin
         errors++;
         $display("FAIL reset_release_w4 got=%h exp=f", y4);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] exp_seq;
      exp_seq = 8'b0010_0101;
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         a1 = 8'b0010_0101;
         s1 = 3'(s);
         @(posedge clk);
         #1;
         checks++;
         if (y1 !== exp_seq[s]) begin
            errors++;
            $display("FAIL sweep s=%0d got=%b exp=%b", s, y1, exp_seq[s]);
         end
      end
   endtask

   task automatic test_walking();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         a1 = 8'd1 << k;
         s1 = 3'(k);
         @(posedge clk);
         #1;
         checks++;
         if (y1 !== 1'b1) begin
            errors++;
            $display("FAIL walk_hit k=%0d got=%b exp=1", k, y1);
         end
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         a1 = 8'd1 << k;
         s1 = 3'((k + 1) % 8);
         @(posedge clk);
         #1;
         checks++;
         if (y1 !== 1'b0) begin
            errors++;
            $display("FAIL walk_miss k=%0d got=%b exp=0", k, y1);
         end
      end
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      a1 = 8'h0F;
      s1 = 3'd0;
      @(posedge clk);
      #1;
      checks++;
      if (y1 !== 1'b1) begin
         errors++;
         $display("FAIL simul_before got=%b exp=1", y1);
      end
      @(negedge clk);
      a1 = 8'hF0;
      s1 = 3'd4;
      @(posedge clk);
      #1;
      checks++;
      if (y1 !== 1'b1) begin
         errors++;
         $display("FAIL simul_after got=%b exp=1", y1);
      end
      @(negedge clk);
      a1 = 8'h0F;
      s1 = 3'd4;
      @(posedge clk);
      #1;
      checks++;
      if (y1 !== 1'b0) begin
         errors++;
         $display("FAIL simul_data_only got=%b exp=0", y1);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      a1 = 8'b0010_0101;
      s1 = 3'd2;
      @(posedge clk);
      #1;
      checks++;
      if (y1 !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre got=%b exp=1", y1);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (y1 !== 1'b0) begin
         errors++;
         $display("FAIL areset_immediate got=%b exp=0", y1);
      end
      @(posedge clk);
      #1;
      checks++;
      if (y1 !== 1'b0) begin
         errors++;
         $display("FAIL areset_held got=%b exp=0", y1);
      end
      @(negedge clk);
      rst = 1'b0;
      s1  = 3'd5;
      #1;
      checks++;
      if (y1 !== 1'b0) begin
         errors++;
         $display("FAIL areset_before_edge got=%b exp=0", y1);
      end
      @(posedge clk);
      #1;
      checks++;
      if (y1 !== 1'b1) begin
         errors++;
         $display("FAIL areset_resume got=%b exp=1", y1);
      end
   endtask

   task automatic test_width4();
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         a4 = 32'h7654_3210;
         s4 = 3'(s);
         @(posedge clk);
         #1;
         checks++;
         if (y4 !== 4'(s)) begin
            errors++;
            $display("FAIL w4_sweep s=%0d got=%h exp=%h", s, y4, 4'(s));
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] exp1;
      logic [3:0] exp4;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         a1 = 8'($urandom);
         s1 = 3'($urandom_range(0, 7));
         a4 = $urandom;
         s4 = 3'($urandom_range(0, 7));
         exp1 = lane_of({24'd0, a1}, int'(s1), 1);
         exp4 = lane_of(a4, int'(s4), 4);
         @(posedge clk);
         #1;
         checks++;
         if (y1 !== exp1[0]) begin
            errors++;
            $display("FAIL rand_w1 n=%0d a=%h s=%0d got=%b exp=%b", n, a1, s1, y1, exp1[0]);
         end
         checks++;
         if (y4 !== exp4) begin
            errors++;
            $display("FAIL rand_w4 n=%0d a=%h s=%0d got=%h exp=%h", n, a4, s4, y4, exp4);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_walking();
      test_simultaneous();
      test_async_reset();
      test_width4();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
